// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: state codes and widths shared by game_ctrl, the datapath and the screen-update logic.
// Rev 1.0
`default_nettype none

package game_ctrl_pkg;

  localparam int GAME_STATE_W    = 3;
  localparam int SCORE_W_DEFAULT = 8;

  typedef logic [GAME_STATE_W-1:0] game_state_t;

  localparam logic [GAME_STATE_W-1:0] ST_MENU      = 3'd0;
  localparam logic [GAME_STATE_W-1:0] ST_MENU_WAIT = 3'd1;
  localparam logic [GAME_STATE_W-1:0] ST_COUNTDOWN = 3'd2;
  localparam logic [GAME_STATE_W-1:0] ST_PLAY      = 3'd3;
  localparam logic [GAME_STATE_W-1:0] ST_PAUSE     = 3'd4;
  localparam logic [GAME_STATE_W-1:0] ST_DEATH     = 3'd5;
  localparam logic [GAME_STATE_W-1:0] ST_OVER      = 3'd6;

endpackage

`default_nettype wire

// File: rtl/game_ctrl_edge_detect.sv
// edge_detect: one-cycle rise pulse for a level key input.
// Rev 1.0
`default_nettype none

module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic rise
);

  // History means "key seen released"; clearing it in reset forces a key held
  // through reset to be released before it can produce a rise.
  logic r_low;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_low <= 1'b0;
    end else begin
      r_low <= ~in;
    end
  end

  assign rise = in & r_low;

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// game_ctrl: jump-game control FSM with countdown, lives, pause, saturating score and high score.
// Rev 1.0 -- pause support built only when GAME_CTRL_PAUSE_EN is defined.
`default_nettype none

module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int SCORE_W         = SCORE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               pause_req,
  input  logic               frame_tick,
  input  logic               endgame,
  output logic               startgame,
  output logic [2:0]         state,
  output logic [3:0]         lives_left,
  output logic [7:0]         countdown,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore,
  output logic               game_over
);

  localparam logic [3:0]         c_lives     = LIVES[3:0];
  localparam logic [7:0]         c_countdown = COUNTDOWN_TICKS[7:0];
  localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};

  logic [2:0]         r_state;
  logic [3:0]         r_lives;
  logic [7:0]         r_countdown;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_hiscore;
  logic               w_go_rise;

  edge_detect u_go_edge (
    .clk    (clk),
    .resetn (resetn),
    .in     (go),
    .rise   (w_go_rise)
  );

`ifdef GAME_CTRL_PAUSE_EN
  logic w_pause_rise;

  edge_detect u_pause_edge (
    .clk    (clk),
    .resetn (resetn),
    .in     (pause_req),
    .rise   (w_pause_rise)
  );
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_req;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_MENU;
      r_lives     <= 4'd0;
      r_countdown <= 8'd0;
      r_score     <= '0;
      r_hiscore   <= '0;
    end else begin
      case (r_state)
        ST_MENU: begin
          if (w_go_rise) r_state <= ST_MENU_WAIT;
        end
        ST_MENU_WAIT: begin
          if (!go) begin
            r_state     <= ST_COUNTDOWN;
            r_score     <= '0;
            r_lives     <= c_lives;
            r_countdown <= c_countdown;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_tick) begin
            r_countdown <= r_countdown - 8'd1;
            if (r_countdown == 8'd1) r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // A death in the same cycle as a tick wins and suppresses the score step.
          if (endgame) begin
            r_state <= ST_DEATH;
          end else begin
            if (frame_tick && (r_score != c_score_max)) r_score <= r_score + 1'b1;
`ifdef GAME_CTRL_PAUSE_EN
            if (w_pause_rise) r_state <= ST_PAUSE;
`endif
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        ST_PAUSE: begin
          if (w_pause_rise) r_state <= ST_PLAY;
        end
`endif
        ST_DEATH: begin
          r_lives <= r_lives - 4'd1;
          if (r_lives == 4'd1) begin
            r_state <= ST_OVER;
            if (r_score > r_hiscore) r_hiscore <= r_score;
          end else begin
            r_state     <= ST_COUNTDOWN;
            r_countdown <= c_countdown;
          end
        end
        ST_OVER: begin
          if (w_go_rise) r_state <= ST_MENU;
        end
        default: begin
          r_state <= ST_MENU;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign startgame  = (r_state == ST_PLAY);
  assign game_over  = (r_state == ST_OVER);
  assign lives_left = r_lives;
  assign countdown  = r_countdown;
  assign score      = r_score;
  assign hiscore    = r_hiscore;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with default parameters.
// Rev 1.0
`default_nettype none

module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic       pause_req;
  logic       frame_tick;
  logic       endgame;
  logic       startgame;
  logic [2:0] state;
  logic [3:0] lives_left;
  logic [7:0] countdown;
  logic [7:0] score;
  logic [7:0] hiscore;
  logic       game_over;

  int passed = 0;
  int total  = 0;
  int exp_score;

  game_ctrl #(
    .LIVES           (3),
    .COUNTDOWN_TICKS (3),
    .SCORE_W         (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .pause_req  (pause_req),
    .frame_tick (frame_tick),
    .endgame    (endgame),
    .startgame  (startgame),
    .state      (state),
    .lives_left (lives_left),
    .countdown  (countdown),
    .score      (score),
    .hiscore    (hiscore),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_go();
    go = 1'b1; cyc();
    go = 1'b0; cyc();
  endtask

  task automatic run_countdown();
    frame_tick = 1'b1;
    repeat (3) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic play(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic die();
    endgame = 1'b1; cyc();
    endgame = 1'b0; cyc();
  endtask

  task automatic test_reset();
    resetn = 1'b0; go = 1'b1; pause_req = 1'b0; frame_tick = 1'b0; endgame = 1'b0;
    repeat (2) cyc();
    total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
    total++; if (startgame !== 1'b0) $display("FAIL reset_startgame: got %0d expected 0", startgame); else passed++;
    total++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %0d expected 0", game_over); else passed++;
    total++; if (lives_left !== 4'd0) $display("FAIL reset_lives: got %0d expected 0", lives_left); else passed++;
    total++; if (countdown !== 8'd0) $display("FAIL reset_countdown: got %0d expected 0", countdown); else passed++;
    total++; if (score !== 8'd0) $display("FAIL reset_score: got %0d expected 0", score); else passed++;
    total++; if (hiscore !== 8'd0) $display("FAIL reset_hiscore: got %0d expected 0", hiscore); else passed++;
    resetn = 1'b1;
    repeat (3) cyc();
    total++; if (state !== 3'd0) $display("FAIL held_go_no_edge: got state %0d expected 0", state); else passed++;
  endtask

  task automatic test_start();
    go = 1'b0; cyc();
    go = 1'b1; cyc();
    total++; if (state !== 3'd1) $display("FAIL start_menu_wait: got %0d expected 1", state); else passed++;
    cyc();
    total++; if (state !== 3'd1) $display("FAIL start_hold_wait: got %0d expected 1", state); else passed++;
    go = 1'b0; cyc();
    total++; if (state !== 3'd2) $display("FAIL start_countdown_state: got %0d expected 2", state); else passed++;
    total++; if (countdown !== 8'd3) $display("FAIL start_countdown_val: got %0d expected 3", countdown); else passed++;
    total++; if (lives_left !== 4'd3) $display("FAIL start_lives: got %0d expected 3", lives_left); else passed++;
    total++; if (score !== 8'd0) $display("FAIL start_score: got %0d expected 0", score); else passed++;
  endtask

  task automatic test_countdown();
    frame_tick = 1'b1; cyc();
    total++; if (countdown !== 8'd2) $display("FAIL cd_first_tick: got %0d expected 2", countdown); else passed++;
    frame_tick = 1'b0; cyc();
    total++; if (countdown !== 8'd2) $display("FAIL cd_no_tick: got %0d expected 2", countdown); else passed++;
    total++; if (startgame !== 1'b0) $display("FAIL cd_startgame: got %0d expected 0", startgame); else passed++;
    frame_tick = 1'b1; cyc();
    total++; if (countdown !== 8'd1) $display("FAIL cd_second_tick: got %0d expected 1", countdown); else passed++;
    cyc();
    frame_tick = 1'b0;
    total++; if (state !== 3'd3) $display("FAIL cd_play_state: got %0d expected 3", state); else passed++;
    total++; if (countdown !== 8'd0) $display("FAIL cd_zero: got %0d expected 0", countdown); else passed++;
    total++; if (startgame !== 1'b1) $display("FAIL cd_startgame_play: got %0d expected 1", startgame); else passed++;
  endtask

  task automatic test_death();
    play(10);
    total++; if (score !== 8'd10) $display("FAIL death_pre_score: got %0d expected 10", score); else passed++;
    endgame = 1'b1; frame_tick = 1'b1; cyc();
    total++; if (state !== 3'd5) $display("FAIL death_state: got %0d expected 5", state); else passed++;
    total++; if (score !== 8'd10) $display("FAIL death_score_frozen: got %0d expected 10", score); else passed++;
    total++; if (startgame !== 1'b0) $display("FAIL death_startgame: got %0d expected 0", startgame); else passed++;
    endgame = 1'b0; frame_tick = 1'b0; cyc();
    total++; if (state !== 3'd2) $display("FAIL death_to_cd: got %0d expected 2", state); else passed++;
    total++; if (lives_left !== 4'd2) $display("FAIL death_lives: got %0d expected 2", lives_left); else passed++;
    total++; if (countdown !== 8'd3) $display("FAIL death_cd_reload: got %0d expected 3", countdown); else passed++;
    total++; if (score !== 8'd10) $display("FAIL death_score_kept: got %0d expected 10", score); else passed++;
    run_countdown(); play(15); die();
    total++; if (lives_left !== 4'd1) $display("FAIL death_lives2: got %0d expected 1", lives_left); else passed++;
    run_countdown();
    endgame = 1'b1; cyc(); endgame = 1'b0;
    total++; if (state !== 3'd5) $display("FAIL last_death_state: got %0d expected 5", state); else passed++;
    cyc();
    total++; if (state !== 3'd6) $display("FAIL over_state: got %0d expected 6", state); else passed++;
    total++; if (game_over !== 1'b1) $display("FAIL over_flag: got %0d expected 1", game_over); else passed++;
    total++; if (lives_left !== 4'd0) $display("FAIL over_lives: got %0d expected 0", lives_left); else passed++;
    total++; if (hiscore !== 8'd25) $display("FAIL over_hiscore_first: got %0d expected 25", hiscore); else passed++;
  endtask

  task automatic test_hiscore();
    press_go();
    total++; if (state !== 3'd0) $display("FAIL over_to_menu: got %0d expected 0", state); else passed++;
    total++; if (score !== 8'd25) $display("FAIL menu_score_held: got %0d expected 25", score); else passed++;
    total++; if (hiscore !== 8'd25) $display("FAIL menu_hiscore_held: got %0d expected 25", hiscore); else passed++;
    press_go();
    total++; if (state !== 3'd2) $display("FAIL game2_start: got %0d expected 2", state); else passed++;
    total++; if (score !== 8'd0) $display("FAIL game2_score_clear: got %0d expected 0", score); else passed++;
    run_countdown(); play(20); die();
    run_countdown(); play(10); die();
    run_countdown(); play(10);
    total++; if (hiscore !== 8'd25) $display("FAIL hiscore_not_early: got %0d expected 25", hiscore); else passed++;
    die();
    total++; if (state !== 3'd6) $display("FAIL game2_over: got %0d expected 6", state); else passed++;
    total++; if (score !== 8'd40) $display("FAIL game2_score: got %0d expected 40", score); else passed++;
    total++; if (hiscore !== 8'd40) $display("FAIL game2_hiscore: got %0d expected 40", hiscore); else passed++;
    press_go(); press_go();
    run_countdown(); play(10); die();
    run_countdown(); die();
    run_countdown(); die();
    total++; if (state !== 3'd6) $display("FAIL game3_over: got %0d expected 6", state); else passed++;
    total++; if (score !== 8'd10) $display("FAIL game3_score: got %0d expected 10", score); else passed++;
    total++; if (hiscore !== 8'd40) $display("FAIL game3_hiscore_kept: got %0d expected 40", hiscore); else passed++;
  endtask

  task automatic test_pause();
    press_go(); press_go();
    run_countdown(); play(5);
    pause_req = 1'b1; frame_tick = 1'b1; cyc();
    pause_req = 1'b0; frame_tick = 1'b0;
    total++; if (score !== 8'd6) $display("FAIL pause_entry_score: got %0d expected 6", score); else passed++;
`ifdef GAME_CTRL_PAUSE_EN
    total++; if (state !== 3'd4) $display("FAIL pause_entry_state: got %0d expected 4", state); else passed++;
    play(5);
    total++; if (score !== 8'd6) $display("FAIL pause_frozen: got %0d expected 6", score); else passed++;
    total++; if (startgame !== 1'b0) $display("FAIL pause_startgame: got %0d expected 0", startgame); else passed++;
    endgame = 1'b1; cyc(); endgame = 1'b0;
    total++; if (state !== 3'd4) $display("FAIL pause_endgame_ignored: got %0d expected 4", state); else passed++;
    pause_req = 1'b1; cyc(); pause_req = 1'b0;
    total++; if (state !== 3'd3) $display("FAIL pause_resume: got %0d expected 3", state); else passed++;
    total++; if (lives_left !== 4'd3) $display("FAIL pause_lives: got %0d expected 3", lives_left); else passed++;
    exp_score = 6;
`else
    total++; if (state !== 3'd3) $display("FAIL nopause_state: got %0d expected 3", state); else passed++;
    play(5);
    total++; if (score !== 8'd11) $display("FAIL nopause_score: got %0d expected 11", score); else passed++;
    endgame = 1'b1; cyc(); endgame = 1'b0;
    total++; if (state !== 3'd5) $display("FAIL nopause_death: got %0d expected 5", state); else passed++;
    cyc();
    total++; if (lives_left !== 4'd2) $display("FAIL nopause_lives: got %0d expected 2", lives_left); else passed++;
    run_countdown();
    total++; if (state !== 3'd3) $display("FAIL nopause_replay: got %0d expected 3", state); else passed++;
    exp_score = 11;
`endif
  endtask

  task automatic test_saturate();
    play(254 - exp_score);
    total++; if (score !== 8'd254) $display("FAIL sat_254: got %0d expected 254", score); else passed++;
    play(1);
    total++; if (score !== 8'd255) $display("FAIL sat_255: got %0d expected 255", score); else passed++;
    play(45);
    total++; if (score !== 8'd255) $display("FAIL sat_no_wrap: got %0d expected 255", score); else passed++;
    total++; if (state !== 3'd3) $display("FAIL sat_state: got %0d expected 3", state); else passed++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    total++; if (state !== 3'd0) $display("FAIL areset_state: got %0d expected 0", state); else passed++;
    total++; if (startgame !== 1'b0) $display("FAIL areset_startgame: got %0d expected 0", startgame); else passed++;
    total++; if (score !== 8'd0) $display("FAIL areset_score: got %0d expected 0", score); else passed++;
    total++; if (hiscore !== 8'd0) $display("FAIL areset_hiscore: got %0d expected 0", hiscore); else passed++;
    total++; if (lives_left !== 4'd0) $display("FAIL areset_lives: got %0d expected 0", lives_left); else passed++;
    cyc();
    resetn = 1'b1;
    cyc();
    total++; if (state !== 3'd0) $display("FAIL areset_release: got %0d expected 0", state); else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_countdown();
    test_death();
    test_hiscore();
    test_pause();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
